// File: rtl/muldiv_issue_sched.sv
// muldiv_issue_sched: reservation station and in-order-by-age issue scheduler
// for the shared multiply/divide unit. Entries live in a compacting queue
// (index 0 = oldest); the oldest fully ready entry issues when the unit is idle.
// Optional performance counters are built when MULDIV_SCHED_PERF_EN is defined.
module muldiv_issue_sched #(
  parameter int DEPTH  = 4,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [PREG_W-1:0] disp_ps1,
  input  logic [PREG_W-1:0] disp_ps2,
  input  logic              disp_ps1_rdy,
  input  logic              disp_ps2_rdy,
  input  logic [PREG_W-1:0] disp_pd,
  input  logic [4:0]        disp_rd,
  input  logic [ROB_W-1:0]  disp_rob,
  input  logic              cdb_valid,
  input  logic [PREG_W-1:0] cdb_preg,
  input  logic              fu_ready,
  output logic              issue_valid,
  output logic [OP_W-1:0]   issue_op,
  output logic [PREG_W-1:0] issue_ps1,
  output logic [PREG_W-1:0] issue_ps2,
  output logic [PREG_W-1:0] issue_pd,
  output logic [4:0]        issue_rd,
  output logic [ROB_W-1:0]  issue_rob
`ifdef MULDIV_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic              rdy1;
    logic              rdy2;
    logic [PREG_W-1:0] pd;
    logic [4:0]        rd;
    logic [ROB_W-1:0]  rob;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  ent_t             woke  [DEPTH];
  ent_t             new_ent;
  logic [CNT_W-1:0] count_q, count_d, wr_idx;
  logic [DEPTH-1:0] rdy_vec;
  logic [IDX_W-1:0] sel;
  logic             any_rdy, do_issue, accept;

  assign disp_ready = (count_q < CNT_W'(DEPTH));
  // A flush cycle drops the dispatch and suppresses any issue.
  assign accept     = disp_valid && disp_ready && !branch_flush;

  // Select the oldest valid entry whose registered ready bits are both set.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++)
      rdy_vec[i] = (CNT_W'(i) < count_q) && ent_q[i].rdy1 && ent_q[i].rdy2;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (rdy_vec[i]) sel = IDX_W'(i);
    any_rdy  = |rdy_vec;
    // !issue_valid hides the unit's one-cycle lag in dropping fu_ready.
    do_issue = fu_ready && !issue_valid && any_rdy && !branch_flush;
  end

  // Next queue contents: CDB wakeup, compaction over the issued slot, append.
  always_comb begin
    new_ent      = '0;
    new_ent.op   = disp_op;
    new_ent.ps1  = disp_ps1;
    new_ent.ps2  = disp_ps2;
    new_ent.rdy1 = disp_ps1_rdy || (cdb_valid && cdb_preg == disp_ps1);
    new_ent.rdy2 = disp_ps2_rdy || (cdb_valid && cdb_preg == disp_ps2);
    new_ent.pd   = disp_pd;
    new_ent.rd   = disp_rd;
    new_ent.rob  = disp_rob;
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (cdb_valid && ent_q[i].ps1 == cdb_preg) woke[i].rdy1 = 1'b1;
      if (cdb_valid && ent_q[i].ps2 == cdb_preg) woke[i].rdy2 = 1'b1;
      ent_d[i] = woke[i];
    end
    for (int i = 0; i < DEPTH - 1; i++)
      if (do_issue && IDX_W'(i) >= sel) ent_d[i] = woke[i + 1];
    // New op lands just past the (possibly compacted) tail.
    wr_idx = count_q - CNT_W'(do_issue);
    for (int i = 0; i < DEPTH; i++)
      if (accept && CNT_W'(i) == wr_idx) ent_d[i] = new_ent;
    count_d = count_q - CNT_W'(do_issue) + CNT_W'(accept);
  end

  // Station state and registered issue port; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || branch_flush) begin
      count_q     <= '0;
      ent_q       <= '{default: '0};
      issue_valid <= 1'b0;
      issue_op    <= '0;
      issue_ps1   <= '0;
      issue_ps2   <= '0;
      issue_pd    <= '0;
      issue_rd    <= '0;
      issue_rob   <= '0;
    end else begin
      count_q     <= count_d;
      ent_q       <= ent_d;
      issue_valid <= do_issue;
      if (do_issue) begin
        issue_op  <= ent_q[sel].op;
        issue_ps1 <= ent_q[sel].ps1;
        issue_ps2 <= ent_q[sel].ps2;
        issue_pd  <= ent_q[sel].pd;
        issue_rd  <= ent_q[sel].rd;
        issue_rob <= ent_q[sel].rob;
      end
    end
  end

`ifdef MULDIV_SCHED_PERF_EN
  // Issue and blocked-ready counters; survive branch flush, wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (do_issue)             perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (any_rdy && !fu_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_issue_sched.sv
// Bench for muldiv_issue_sched: hand-derived cycle table for the directed
// scenarios, then random traffic checked against a queue-based model.
// Perf counter checks are compiled in with MULDIV_SCHED_PERF_EN.
module tb_muldiv_issue_sched;
  localparam int DEPTH = 4;
  localparam logic [3:0] MUL = 4'd0;
  localparam logic [3:0] DIV = 4'd4;

  logic       clk = 1'b0;
  logic       rst, branch_flush, disp_valid, disp_ready;
  logic [3:0] disp_op;
  logic [5:0] disp_ps1, disp_ps2, disp_pd;
  logic       disp_ps1_rdy, disp_ps2_rdy;
  logic [4:0] disp_rd, disp_rob;
  logic       cdb_valid;
  logic [5:0] cdb_preg;
  logic       fu_ready, issue_valid;
  logic [3:0] issue_op;
  logic [5:0] issue_ps1, issue_ps2, issue_pd;
  logic [4:0] issue_rd, issue_rob;
`ifdef MULDIV_SCHED_PERF_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

  muldiv_issue_sched #(.DEPTH(DEPTH), .PREG_W(6), .ROB_W(5), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .branch_flush(branch_flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
    .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
    .disp_pd(disp_pd), .disp_rd(disp_rd), .disp_rob(disp_rob),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_ps1(issue_ps1),
    .issue_ps2(issue_ps2), .issue_pd(issue_pd), .issue_rd(issue_rd),
    .issue_rob(issue_rob)
`ifdef MULDIV_SCHED_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: age-ordered queue ----------------
  typedef struct {
    logic [3:0] op;
    logic [5:0] ps1, ps2, pd;
    bit         r1, r2;
    logic [4:0] rd, rob;
  } ment_t;

  ment_t       mq[$];
  bit          m_iv = 0;
  ment_t       m_is = '{default: 0};
  logic [31:0] m_icnt = 0, m_scnt = 0;

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int    idx;
    bit    acc, iss;
    ment_t n;
    idx = -1;
    foreach (mq[i]) if (idx < 0 && mq[i].r1 && mq[i].r2) idx = i;
    if (rst) begin
      m_icnt = 0;
      m_scnt = 0;
    end else if (idx >= 0 && !fu_ready) begin
      m_scnt++;
    end
    if (rst || branch_flush) begin
      mq.delete();
      m_iv = 0;
      m_is = '{default: 0};
      return;
    end
    acc = disp_valid && (mq.size() < DEPTH);
    iss = fu_ready && !m_iv && (idx >= 0);
    if (iss) begin
      m_is = mq[idx];
      mq.delete(idx);
      m_icnt++;
    end
    m_iv = iss;
    if (cdb_valid)
      foreach (mq[i]) begin
        if (mq[i].ps1 == cdb_preg) mq[i].r1 = 1;
        if (mq[i].ps2 == cdb_preg) mq[i].r2 = 1;
      end
    if (acc) begin
      n.op  = disp_op;  n.ps1 = disp_ps1; n.ps2 = disp_ps2;
      n.pd  = disp_pd;  n.rd  = disp_rd;  n.rob = disp_rob;
      n.r1  = disp_ps1_rdy || (cdb_valid && cdb_preg == disp_ps1);
      n.r2  = disp_ps2_rdy || (cdb_valid && cdb_preg == disp_ps2);
      mq.push_back(n);
    end
  endtask

  task automatic model_chk();
    chk("m_issue_valid", 32'(issue_valid), 32'(m_iv));
    chk("m_disp_ready",  32'(disp_ready),  32'(mq.size() < DEPTH));
    chk("m_issue_fields", {issue_op, issue_ps1, issue_ps2, issue_pd, issue_rd, issue_rob},
        {m_is.op, m_is.ps1, m_is.ps2, m_is.pd, m_is.rd, m_is.rob});
`ifdef MULDIV_SCHED_PERF_EN
    chk("perf_issue_cnt", perf_issue_cnt, m_icnt);
    chk("perf_stall_cnt", perf_stall_cnt, m_scnt);
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         rst, fl, dv;
    logic [3:0] op;
    logic [5:0] ps1, ps2;
    bit         r1, r2;
    logic [4:0] rob;
    bit         cv;
    logic [5:0] cp;
    bit         fu;
    bit         e_iv, e_dr;
    logic [4:0] e_rob;
    bit         chkf;
    logic [3:0] e_op;
    logic [5:0] e_ps1, e_ps2;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rs, bit fl, bit dv, logic [3:0] op, logic [5:0] ps1,
                              logic [5:0] ps2, bit r1, bit r2, logic [4:0] rob, bit cv,
                              logic [5:0] cp, bit fu, bit eiv, bit edr, logic [4:0] erob,
                              bit chkf = 0, logic [3:0] eop = 0, logic [5:0] eps1 = 0,
                              logic [5:0] eps2 = 0);
    vec_t v;
    v.rst = rs; v.fl = fl; v.dv = dv; v.op = op; v.ps1 = ps1; v.ps2 = ps2;
    v.r1 = r1; v.r2 = r2; v.rob = rob; v.cv = cv; v.cp = cp; v.fu = fu;
    v.e_iv = eiv; v.e_dr = edr; v.e_rob = erob;
    v.chkf = chkf; v.e_op = eop; v.e_ps1 = eps1; v.e_ps2 = eps2;
    tbl.push_back(v);
  endfunction

  // idle row: only fu_ready driven
  function automatic void idl(bit fu, bit eiv, bit edr, logic [4:0] erob);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fu, eiv, edr, erob);
  endfunction

  initial begin
    rst = 1; branch_flush = 0; disp_valid = 0; disp_op = 0; disp_ps1 = 0; disp_ps2 = 0;
    disp_ps1_rdy = 0; disp_ps2_rdy = 0; disp_pd = 0; disp_rd = 0; disp_rob = 0;
    cdb_valid = 0; cdb_preg = 0; fu_ready = 0;

    // reset state
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    // ready MUL: issue 2 cycles after accept
    add(0, 0, 1, MUL, 3, 4, 1, 1, 2, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 1, MUL, 3, 4);
    idl(1, 0, 1, 2);
    // DIV waits on preg 9, broadcast two cycles later
    add(0, 0, 1, DIV, 5, 9, 1, 0, 3, 0, 0, 1, 0, 1, 2);
    idl(1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 1, DIV, 5, 9);
    idl(1, 0, 1, 3);
    // same-cycle broadcast bypass at dispatch
    add(0, 0, 1, DIV, 5, 9, 1, 0, 4, 1, 9, 1, 0, 1, 3);
    idl(1, 1, 1, 4);
    idl(1, 0, 1, 4);
    // fill with unit busy; 5th and full-cycle dispatches refused
    add(0, 0, 1, MUL, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 4);
    add(0, 0, 1, MUL, 1, 2, 1, 1, 1, 0, 0, 0, 0, 1, 4);
    add(0, 0, 1, MUL, 1, 2, 1, 1, 2, 0, 0, 0, 0, 1, 4);
    add(0, 0, 1, MUL, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, 4);
    add(0, 0, 1, MUL, 1, 2, 1, 1, 5, 0, 0, 0, 0, 0, 4);
    add(0, 0, 1, MUL, 1, 2, 1, 1, 6, 0, 0, 1, 1, 1, 0);
    idl(1, 0, 1, 0);
    idl(1, 1, 1, 1); idl(1, 0, 1, 1);
    idl(1, 1, 1, 2); idl(1, 0, 1, 2);
    idl(1, 1, 1, 3); idl(1, 0, 1, 3);
    idl(1, 0, 1, 3);
    // younger ready entry overtakes older blocked one
    add(0, 0, 1, MUL, 10, 2, 0, 1, 7, 0, 0, 0, 0, 1, 3);
    add(0, 0, 1, MUL, 1, 2, 1, 1, 8, 0, 0, 0, 0, 1, 3);
    idl(1, 1, 1, 8);
    idl(1, 0, 1, 8);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 1, 0, 1, 8);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 1, MUL, 10, 2);
    idl(1, 0, 1, 7);
    // flush with 3 entries and issue_valid high; flush-cycle dispatch dropped
    add(0, 0, 1, MUL, 1, 2, 1, 1, 9,  0, 0, 0, 0, 1, 7);
    add(0, 0, 1, MUL, 1, 2, 1, 1, 10, 0, 0, 0, 0, 1, 7);
    add(0, 0, 1, MUL, 1, 2, 1, 1, 11, 0, 0, 0, 0, 1, 7);
    add(0, 0, 1, MUL, 1, 2, 1, 1, 12, 0, 0, 0, 0, 0, 7);
    idl(1, 1, 1, 9);
    add(0, 1, 1, MUL, 1, 2, 1, 1, 13, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    idl(1, 0, 1, 0);
    idl(1, 0, 1, 0);

    foreach (tbl[k]) begin
      rst = tbl[k].rst; branch_flush = tbl[k].fl; disp_valid = tbl[k].dv;
      disp_op = tbl[k].op; disp_ps1 = tbl[k].ps1; disp_ps2 = tbl[k].ps2;
      disp_ps1_rdy = tbl[k].r1; disp_ps2_rdy = tbl[k].r2; disp_rob = tbl[k].rob;
      disp_pd = {1'b1, tbl[k].rob}; disp_rd = tbl[k].rob;
      cdb_valid = tbl[k].cv; cdb_preg = tbl[k].cp; fu_ready = tbl[k].fu;
      cycle();
      chk($sformatf("row%0d issue_valid", k), 32'(issue_valid), 32'(tbl[k].e_iv));
      chk($sformatf("row%0d disp_ready", k),  32'(disp_ready),  32'(tbl[k].e_dr));
      chk($sformatf("row%0d issue_rob", k),   32'(issue_rob),   32'(tbl[k].e_rob));
      if (tbl[k].chkf)
        chk($sformatf("row%0d op/ps1/ps2", k), {issue_op, issue_ps1, issue_ps2},
            {tbl[k].e_op, tbl[k].e_ps1, tbl[k].e_ps2});
      model_chk();
    end

    // ---------------- random traffic vs model ----------------
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 499) == 0);
      branch_flush = ($urandom_range(0, 49) == 0);
      disp_valid   = ($urandom_range(0, 99) < 55);
      disp_op      = 4'($urandom_range(0, 7));
      disp_ps1     = 6'($urandom_range(0, 7));
      disp_ps2     = 6'($urandom_range(0, 7));
      disp_ps1_rdy = ($urandom_range(0, 2) == 0);
      disp_ps2_rdy = ($urandom_range(0, 2) == 0);
      disp_pd      = 6'($urandom);
      disp_rd      = 5'($urandom);
      disp_rob     = 5'($urandom);
      cdb_valid    = ($urandom_range(0, 99) < 45);
      cdb_preg     = 6'($urandom_range(0, 7));
      fu_ready     = ($urandom_range(0, 99) < 60);
      cycle();
      model_chk();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_issue_sched.md
# muldiv_issue_sched

Reservation station and issue scheduler for the shared multiply/divide functional unit. It buffers renamed M-extension ops from dispatch and wakes up their source operands from the CDB. It issues the oldest fully ready op to the multi-cycle MUL/DIV unit, one at a time, honouring that unit's ready handshake. All state is discarded on branch flush.

## Interface
Parameters:
- DEPTH, 4: number of station entries (2..8).
- PREG_W, 6: physical register index width.
- ROB_W, 5: ROB index width.
- OP_W, 4: op (funct3-derived mulop) width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- branch_flush  in  1  discard all entries and any pending issue.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  station can accept this cycle.
- disp_op  in  OP_W  mulop.
- disp_ps1, disp_ps2  in  PREG_W  source pregs.
- disp_ps1_rdy, disp_ps2_rdy  in  1  source already available at rename.
- disp_pd  in  PREG_W  destination preg.
- disp_rd  in  5  destination areg.
- disp_rob  in  ROB_W  ROB index.
- cdb_valid  in  1  broadcast valid.
- cdb_preg  in  PREG_W  broadcast preg.
- fu_ready  in  1  MUL/DIV unit idle (its registered ready).
- issue_valid  out  1  one-cycle issue strobe to the unit.
- issue_op, issue_ps1, issue_ps2, issue_pd, issue_rd, issue_rob  out  (as dispatch)  issued entry fields.

## Operation
- Storage is a compacting queue. Entry 0 is the oldest. Valid entries are contiguous from 0. count is in 0..DEPTH.
- disp_ready = (count < DEPTH). It is computed from registered count only; a same-cycle issue does not free a slot.
- Accept: disp_valid && disp_ready. The new entry is written at index count, after compaction if an issue occurs in the same cycle.
- Wakeup: on cdb_valid, every valid entry whose ps1 (or ps2) equals cdb_preg sets its rdy1 (or rdy2).
- Dispatch bypass: an accepted op whose source equals cdb_preg while cdb_valid is high is stored ready.
- Select: the lowest-index entry with rdy1 && rdy2, using registered ready bits. A wakeup in cycle t makes the entry selectable in t+1 at the earliest.
- Issue condition: fu_ready && !issue_valid && a ready entry exists. The !issue_valid term covers the unit's one-cycle lag in dropping fu_ready.
- On issue:
  - The selected entry is removed.
  - Entries above it shift down by one.
  - Its fields are registered onto issue_*.
  - issue_valid is asserted the next cycle for exactly one cycle.
- issue_* fields hold their last value when issue_valid is 0.
- Flush: branch_flush has the same effect as rst on all state. A dispatch presented in the flush cycle is dropped. CDB wakeups in that cycle are ignored.

## Timing
- Reset and flush values:
  - count = 0, all entry valid and ready bits = 0.
  - disp_ready = 1, issue_valid = 0, issue_* = 0.
- Dispatch to issue latency, operands ready at dispatch and unit idle:
  - Accept at edge t.
  - Selected in cycle t+1.
  - issue_valid high in cycle t+2.
- Wakeup in cycle t: entry selected in t+1, issue_valid high in t+2.
- Back-to-back issue:
  - Second issue_valid occurs no earlier than the cycle after fu_ready returns high.
  - Never two issue_valid pulses in consecutive cycles.
- Full station with a same-cycle issue: disp_ready stays 0 that cycle. The freed slot is visible next cycle.
- Age order: among simultaneously ready entries, the earliest dispatched issues first. Compaction preserves relative order.

## Configuration
- MULDIV_SCHED_PERF_EN defined:
  - Adds outputs perf_issue_cnt[31:0] (issues) and perf_stall_cnt[31:0] (cycles with a ready entry but fu_ready = 0).
  - Both counters wrap at 2^32.
  - Both are cleared by rst only, not by branch_flush.
- MULDIV_SCHED_PERF_EN undefined: ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then dispatch MUL with ps1 = 3 and ps2 = 4, both ready, rob = 2, fu_ready = 1 → issue_valid pulses exactly 2 cycles after accept with issue_op = MUL, issue_rob = 2, issue_ps1 = 3, issue_ps2 = 4.
- Dispatch DIV with ps2 = 9 not ready, then cdb_valid with cdb_preg = 9 two cycles later → issue_valid exactly 2 cycles after the broadcast. Same-cycle dispatch with cdb_preg = 9 → stored ready, no stall.
- Fill 4 entries (ready), hold fu_ready = 0 → disp_ready = 0 and a 5th dispatch is not accepted. Then pulse fu_ready → issues come out in rob order 0, 1, 2, 3, each separated by at least 2 cycles.
- Entries 0 (not ready) and 1 (ready) → entry 1 issues first. Entry 0 later shifts to index 0 and issues after wakeup.
- branch_flush while 3 entries are valid and issue_valid = 1 → next cycle count = 0, issue_valid = 0, disp_ready = 1. A dispatch in the flush cycle is discarded.
- With MULDIV_SCHED_PERF_EN: 3 issues plus 5 cycles of ready-but-blocked → perf_issue_cnt = 3, perf_stall_cnt = 5. Flush leaves both unchanged.
